// File: rtl/nascom_sim_pkg.sv
// Constants shared by the NASCOM timing-chain blocks: divider terminal modes
// and the counter slice width.
package nascom_sim_pkg;
  localparam logic DIV_MODE_WRAP   = 1'b0;
  localparam logic DIV_MODE_RELOAD = 1'b1;
  localparam int   NIB             = 4;
endpackage

// File: rtl/sync_down_divider_if.sv
// Control and status bundle for sync_down_divider.
// Handshake: none; every input is sampled at each rising clk edge, q and tick
// are registered, and bo_n is combinational from q and ent.
interface sync_down_divider_if #(
  parameter int WIDTH = 8
) ();
  logic             load_n;
  logic [WIDTH-1:0] d;
  logic             enp;
  logic             ent;
  logic             mode;
  logic [WIDTH-1:0] q;
  logic             bo_n;
  logic             tick;

  modport master (
    output load_n, d, enp, ent, mode,
    input  q, bo_n, tick
  );

  modport slave (
    input  load_n, d, enp, ent, mode,
    output q, bo_n, tick
  );
endinterface

// File: rtl/sync_down_divider_down_nibble.sv
// One 4-bit down-count slice with synchronous load and trickle enable.
// borrow_out enables the next slice up when this slice is about to wrap.
module down_nibble
  import nascom_sim_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [NIB-1:0] ld_val,
  input  logic           ent_in,
  output logic [NIB-1:0] q,
  output logic           borrow_out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= ld_val;
    end else if (ent_in) begin
      q <= q - 1'b1;
    end
  end

  assign borrow_out = ent_in && (q == '0);

endmodule

// File: rtl/sync_down_divider.sv
// Cascadable synchronous down-counter / divider built from 4-bit slices.
// Terminal count either wraps to all-ones or reloads from the last loaded value.
module sync_down_divider
  import nascom_sim_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  sync_down_divider_if.slave bus
);

  localparam int NS = WIDTH / NIB;

  if ((WIDTH % NIB) != 0 || WIDTH < NIB) begin : g_bad_width
    $error("sync_down_divider: WIDTH must be a multiple of 4 and at least 4");
  end

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rl;
  logic [WIDTH-1:0] ld_val;
  logic [NS:0]      chain;
  logic             load;
  logic             term;
  logic             tick;

  // The top of the borrow chain is high exactly on an enabled step at zero
  // with no external load pending, i.e. the terminal event.
  assign chain[0] = bus.enp && bus.ent && bus.load_n;
  assign term     = chain[NS];
  assign load     = !bus.load_n || (term && (bus.mode == DIV_MODE_RELOAD));
  assign ld_val   = bus.load_n ? rl : bus.d;

  for (genvar g = 0; g < NS; g++) begin : g_slice
    down_nibble u_nib (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .ld_val     (ld_val[g*NIB +: NIB]),
      .ent_in     (chain[g]),
      .q          (q[g*NIB +: NIB]),
      .borrow_out (chain[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rl   <= '0;
      tick <= 1'b0;
    end else begin
      if (!bus.load_n) rl <= bus.d;
      tick <= term;
    end
  end

  // Borrow ignores enp so ENP-only stalls in a cascade do not hide it.
  assign bus.bo_n = !(bus.ent && (q == '0));
  assign bus.q    = q;
  assign bus.tick = tick;

endmodule
